permutation_engine: RTL



---
 rtl/ascon_aead128_pkg.sv | 70 +++++++
 rtl/permutation_engine_if.sv | 14 +
 rtl/permutation.sv | 13 +
 rtl/permutation_engine.sv | 102 ++++++++++
 4 files changed

// File: rtl/ascon_aead128_pkg.sv
// Shared Ascon AEAD128 types, round constants and the single-round function.
package ascon_aead128_pkg;

   localparam int unsigned WORD_W = 64;
   localparam int unsigned RND_W  = 4;

   // x0 occupies the most significant 64 bits of the 320-bit state
   typedef struct packed {
      logic [WORD_W-1:0] x0;
      logic [WORD_W-1:0] x1;
      logic [WORD_W-1:0] x2;
      logic [WORD_W-1:0] x3;
      logic [WORD_W-1:0] x4;
   } ascon_state;

   typedef logic [RND_W-1:0] rnd_t;

   localparam rnd_t P12_FIRST_RND = RND_W'(0);
   localparam rnd_t P8_FIRST_RND  = RND_W'(4);
   localparam rnd_t LAST_RND      = RND_W'(11);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } perm_fsm_t;

   // Rotate a 64-bit word right by n (n in 1..63)
   function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] x, input int unsigned n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

   // One Ascon round: constant addition, bitsliced 5-bit S-box, linear diffusion
   function automatic ascon_state round(input ascon_state s, input rnd_t rnd);
      logic [WORD_W-1:0] x0, x1, x2, x3, x4;
      logic [WORD_W-1:0] t0, t1, t2, t3, t4;
      ascon_state        r;
      x0 = s.x0;
      x1 = s.x1;
      x2 = s.x2;
      x3 = s.x3;
      x4 = s.x4;
      // constant 0xF0 - 0x0F*i equals {15-i, i} for i in 0..11
      x2 = x2 ^ WORD_W'({~rnd, rnd});
      x0 = x0 ^ x4;
      x4 = x4 ^ x3;
      x2 = x2 ^ x1;
      t0 = ~x0 & x1;
      t1 = ~x1 & x2;
      t2 = ~x2 & x3;
      t3 = ~x3 & x4;
      t4 = ~x4 & x0;
      x0 = x0 ^ t1;
      x1 = x1 ^ t2;
      x2 = x2 ^ t3;
      x3 = x3 ^ t4;
      x4 = x4 ^ t0;
      x1 = x1 ^ x0;
      x0 = x0 ^ x4;
      x3 = x3 ^ x2;
      x2 = ~x2;
      r.x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
      r.x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
      r.x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
      r.x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
      r.x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
      return r;
   endfunction

endpackage

// File: rtl/permutation_engine_if.sv
// Controller <-> permutation engine handshake and state bus.
interface permutation_engine_if;
   import ascon_aead128_pkg::*;

   logic       start;
   logic       p8;
   ascon_state state_in;
   logic       ready;
   logic       done;
   ascon_state state_out;

   modport master (output start, p8, state_in, input ready, done, state_out);
   modport slave  (input start, p8, state_in, output ready, done, state_out);
endinterface

// File: rtl/permutation.sv
// Combinational single Ascon round stage.
module permutation
   import ascon_aead128_pkg::*;
(
   input  ascon_state state_in,
   input  rnd_t       rnd,
   output ascon_state state_out
);

   // apply round with index rnd
   assign state_out = round(state_in, rnd);

endmodule

// File: rtl/permutation_engine.sv
// Sequential Ascon p^12 / p^8 engine: UNROLL rounds per cycle, start/ready/done handshake.
module permutation_engine
   import ascon_aead128_pkg::*;
#(
   parameter int unsigned UNROLL = 1
) (
   input logic                 clk,
   input logic                 rst_n,
   permutation_engine_if.slave bus
);

   if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
      $error("permutation_engine: UNROLL must be 1, 2 or 4");
   end

   localparam rnd_t RND_STEP = RND_W'(UNROLL);
   localparam rnd_t RND_SPAN = RND_W'(UNROLL - 1);

   perm_fsm_t  state;
   perm_fsm_t  state_nxt;
   ascon_state state_reg;
   rnd_t       rnd_reg;
   logic       ready_q;
   logic       done_q;
   logic       ready_d;
   logic       done_d;
   logic       accept_c;
   logic       last_c;
   ascon_state chain [UNROLL+1];

   // a start is taken in IDLE and in the DONE cycle (back-to-back)
   assign accept_c = (state != RUN) && bus.start;
   // the highest round index applied this cycle is the final one
   assign last_c   = (rnd_reg + RND_SPAN) == LAST_RND;

   // unrolled round chain, stage k uses index rnd_reg+k
   assign chain[0] = state_reg;
   for (genvar k = 0; k < UNROLL; k++) begin : g_round
      permutation u_round (
         .state_in  (chain[k]),
         .rnd       (rnd_reg + RND_W'(k)),
         .state_out (chain[k+1])
      );
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // FSM next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN:     if (last_c)    state_nxt = DONE;
         DONE:    state_nxt = bus.start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM output decode, taken from the upcoming state so outputs are registered
   always_comb begin
      ready_d = 1'b1;
      done_d  = 1'b0;
      if (state_nxt == RUN)  ready_d = 1'b0;
      if (state_nxt == DONE) done_d  = 1'b1;
   end

   // handshake output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         ready_q <= ready_d;
         done_q  <= done_d;
      end
   end

   // state register and round counter; the counter parks at 0 outside RUN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= '0;
         rnd_reg   <= '0;
      end else if (accept_c) begin
         state_reg <= bus.state_in;
         rnd_reg   <= bus.p8 ? P8_FIRST_RND : P12_FIRST_RND;
      end else if (state == RUN) begin
         state_reg <= chain[UNROLL];
         rnd_reg   <= rnd_reg + RND_STEP;
      end else begin
         rnd_reg   <= '0;
      end
   end

   assign bus.ready     = ready_q;
   assign bus.done      = done_q;
   assign bus.state_out = state_reg;

endmodule
